// File: rtl/noc_params.sv
// Shared NoC parameters: output-port encoding and default mesh geometry.
package noc_params;

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    SOUTH = 3'd2,
    WEST  = 3'd3,
    EAST  = 3'd4
  } port_t;

  localparam int MESH_SIZE_X      = 5;
  localparam int MESH_SIZE_Y      = 7;
  localparam int DEST_ADDR_SIZE_X = $clog2(MESH_SIZE_X);
  localparam int DEST_ADDR_SIZE_Y = $clog2(MESH_SIZE_Y);

endpackage

// File: rtl/rc_unit.sv
// XY dimension-order route computation: combinational port decode plus a
// one-cycle registered copy with valid and out-of-mesh destination flag.
module rc_unit
  import noc_params::*;
#(
  parameter int MESH_SIZE_X      = noc_params::MESH_SIZE_X,
  parameter int MESH_SIZE_Y      = noc_params::MESH_SIZE_Y,
  parameter int X_CURRENT        = MESH_SIZE_X / 2,
  parameter int Y_CURRENT        = MESH_SIZE_Y / 2,
  parameter int DEST_ADDR_SIZE_X = $clog2(MESH_SIZE_X),
  parameter int DEST_ADDR_SIZE_Y = $clog2(MESH_SIZE_Y)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DEST_ADDR_SIZE_X-1:0] x_dest_i,
  input  logic [DEST_ADDR_SIZE_Y-1:0] y_dest_i,
  input  logic                        valid_i,
  output port_t                       out_port_o,
  output port_t                       out_port_q_o,
  output logic                        valid_q_o,
  output logic                        dest_err_q_o
);

  // One extra bit so a power-of-two mesh size still fits in the compare.
  localparam int XW = DEST_ADDR_SIZE_X + 1;
  localparam int YW = DEST_ADDR_SIZE_Y + 1;
  localparam logic [XW-1:0] X_CUR  = XW'(X_CURRENT);
  localparam logic [YW-1:0] Y_CUR  = YW'(Y_CURRENT);
  localparam logic [XW-1:0] X_SIZE = XW'(MESH_SIZE_X);
  localparam logic [YW-1:0] Y_SIZE = YW'(MESH_SIZE_Y);

  logic [XW-1:0] x_ext;
  logic [YW-1:0] y_ext;
  logic          out_of_range;

  assign x_ext        = {1'b0, x_dest_i};
  assign y_ext        = {1'b0, y_dest_i};
  assign out_of_range = (x_ext >= X_SIZE) || (y_ext >= Y_SIZE);

  // X resolved first; Y only consulted once the column matches.
  always_comb begin
    out_port_o = LOCAL;
    if (x_ext < X_CUR)      out_port_o = WEST;
    else if (x_ext > X_CUR) out_port_o = EAST;
    else if (y_ext < Y_CUR) out_port_o = NORTH;
    else if (y_ext > Y_CUR) out_port_o = SOUTH;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_port_q_o <= LOCAL;
      valid_q_o    <= 1'b0;
      dest_err_q_o <= 1'b0;
    end else begin
      valid_q_o    <= valid_i;
      dest_err_q_o <= valid_i & out_of_range;
      if (valid_i) out_port_q_o <= out_port_o;
    end
  end

endmodule

// File: tb/tb_rc_unit.sv
// Directed bench for rc_unit: default 5x7 mesh at (2,3) plus a corner
// router instance at (0,0).
module tb_rc_unit;
  import noc_params::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] x_dest, y_dest;
  logic       valid;
  port_t      out_port, out_port_q;
  logic       valid_q, dest_err_q;

  logic [2:0] x0, y0;
  port_t      out_port0, out_port_q0;
  logic       valid_q0, dest_err_q0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rc_unit dut (
    .clk(clk), .rst(rst), .x_dest_i(x_dest), .y_dest_i(y_dest),
    .valid_i(valid), .out_port_o(out_port), .out_port_q_o(out_port_q),
    .valid_q_o(valid_q), .dest_err_q_o(dest_err_q)
  );

  rc_unit #(.X_CURRENT(0), .Y_CURRENT(0)) dut0 (
    .clk(clk), .rst(rst), .x_dest_i(x0), .y_dest_i(y0),
    .valid_i(1'b0), .out_port_o(out_port0), .out_port_q_o(out_port_q0),
    .valid_q_o(valid_q0), .dest_err_q_o(dest_err_q0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive inputs on the falling edge, away from the capture edge.
  task automatic drive(input logic v, input logic [2:0] x, input logic [2:0] y);
    @(negedge clk);
    valid = v; x_dest = x; y_dest = y;
    #1;
  endtask

  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    port_t exp_p;
    rst = 1'b1; valid = 1'b0; x_dest = 3'd0; y_dest = 3'd0; x0 = 3'd0; y0 = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_q_port", out_port_q, LOCAL);
    chk("reset_valid",  valid_q, 1'b0);
    chk("reset_err",    dest_err_q, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Full sweep of the 5x7 mesh, registered path idle.
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 7; y++) begin
        x_dest = 3'(x); y_dest = 3'(y);
        #1;
        exp_p = (x < 2) ? WEST : (x > 2) ? EAST : (y < 3) ? NORTH : (y > 3) ? SOUTH : LOCAL;
        chk($sformatf("sweep_%0d_%0d", x, y), out_port, exp_p);
      end

    // Hand-picked points and X priority.
    x_dest = 3'd0; y_dest = 3'd5; #1; chk("pt_0_5_west",  out_port, WEST);
    x_dest = 3'd4; y_dest = 3'd0; #1; chk("pt_4_0_east",  out_port, EAST);
    x_dest = 3'd2; y_dest = 3'd0; #1; chk("pt_2_0_north", out_port, NORTH);
    x_dest = 3'd2; y_dest = 3'd6; #1; chk("pt_2_6_south", out_port, SOUTH);
    x_dest = 3'd2; y_dest = 3'd3; #1; chk("pt_2_3_local", out_port, LOCAL);
    x_dest = 3'd1; y_dest = 3'd0; #1; chk("xprio_1_0",    out_port, WEST);
    x_dest = 3'd3; y_dest = 3'd6; #1; chk("xprio_3_6",    out_port, EAST);
    chk("idle_valid_q", valid_q, 1'b0);
    chk("idle_q_port",  out_port_q, LOCAL);

    // Registered path: capture then hold.
    drive(1'b1, 3'd4, 3'd3);
    edge_settle();
    chk("reg_east_q",     out_port_q, EAST);
    chk("reg_east_valid", valid_q, 1'b1);
    chk("reg_east_err",   dest_err_q, 1'b0);
    drive(1'b0, 3'd0, 3'd0);
    chk("hold_comb_west", out_port, WEST);
    edge_settle();
    chk("hold_q_east",  out_port_q, EAST);
    chk("hold_valid_0", valid_q, 1'b0);

    // Range check.
    drive(1'b1, 3'd6, 3'd3);
    chk("oor_x_comb", out_port, EAST);
    edge_settle();
    chk("oor_x_err", dest_err_q, 1'b1);
    chk("oor_x_q",   out_port_q, EAST);
    drive(1'b1, 3'd2, 3'd7);
    chk("oor_y_comb", out_port, SOUTH);
    edge_settle();
    chk("oor_y_err", dest_err_q, 1'b1);
    chk("oor_y_q",   out_port_q, SOUTH);
    drive(1'b1, 3'd2, 3'd3);
    chk("inr_comb", out_port, LOCAL);
    edge_settle();
    chk("inr_err", dest_err_q, 1'b0);
    chk("inr_q",   out_port_q, LOCAL);
    // Out-of-range without valid must not raise the flag.
    drive(1'b1, 3'd7, 3'd7);
    edge_settle();
    chk("oor_both_err", dest_err_q, 1'b1);
    drive(1'b0, 3'd7, 3'd7);
    edge_settle();
    chk("oor_novalid_err", dest_err_q, 1'b0);

    // Asynchronous reset mid-stream.
    drive(1'b1, 3'd2, 3'd6);
    edge_settle();
    chk("pre_rst_q",     out_port_q, SOUTH);
    chk("pre_rst_valid", valid_q, 1'b1);
    drive(1'b1, 3'd6, 3'd0);
    edge_settle();
    chk("pre_rst_err", dest_err_q, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_q",     out_port_q, LOCAL);
    chk("async_rst_valid", valid_q, 1'b0);
    chk("async_rst_err",   dest_err_q, 1'b0);
    x_dest = 3'd0; y_dest = 3'd2; #1;
    chk("rst_comb_west", out_port, WEST);
    edge_settle();
    chk("rst_hold_valid", valid_q, 1'b0);
    chk("rst_hold_q",     out_port_q, LOCAL);
    drive(1'b1, 3'd4, 3'd0);
    rst = 1'b0;
    edge_settle();
    chk("post_rst_q",     out_port_q, EAST);
    chk("post_rst_valid", valid_q, 1'b1);

    // Corner router at (0,0).
    x0 = 3'd0; y0 = 3'd0; #1; chk("c00_local", out_port0, LOCAL);
    x0 = 3'd0; y0 = 3'd3; #1; chk("c03_south", out_port0, SOUTH);
    x0 = 3'd1; y0 = 3'd0; #1; chk("c10_east",  out_port0, EAST);
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 7; y++) begin
        x0 = 3'(x); y0 = 3'(y);
        #1;
        exp_p = (x > 0) ? EAST : (y > 0) ? SOUTH : LOCAL;
        chk($sformatf("corner_%0d_%0d", x, y), out_port0, exp_p);
      end
    chk("corner_valid_q", valid_q0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
